// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial source stage.
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_e;

    // A length of 0, or anything beyond the word width, means a full word.
    function automatic int unsigned norm_len(input int unsigned len, input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial stage with valid/ready load and back-to-back streaming.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no word in flight, ready for a load
// ST_SHIFT  | data bits on out, cnt counts down to the final data bit
// ST_PARITY | parity trailer on out (only with SERIALIZER_PARITY_EN)
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    ser_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] eff_len;
    logic             shift_st;
    logic             final_bit;
    logic             accept;

    assign eff_len   = LEN_W'(norm_len(32'(load_len), WIDTH));
    assign shift_st  = (state_q == ST_SHIFT);
    assign final_bit = shift_st && (cnt_q == LEN_W'(1));
    assign busy      = (state_q != ST_IDLE);
    assign accept    = load_valid && load_ready;

`ifdef SERIALIZER_PARITY_EN
    logic par_q, par_d;
    logic par_st;

    assign par_st     = (state_q == ST_PARITY);
    assign out        = (shift_st && shreg_q[WIDTH-1]) || (par_st && par_q);
    assign out_valid  = shift_st || par_st;
    assign last       = par_st;
    assign load_ready = (state_q == ST_IDLE) || par_st;
`else
    assign out        = shift_st && shreg_q[WIDTH-1];
    assign out_valid  = shift_st;
    assign last       = final_bit;
    assign load_ready = (state_q == ST_IDLE) || final_bit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - LEN_W'(1);
`ifdef SERIALIZER_PARITY_EN
                par_d   = par_q ^ shreg_q[WIDTH-1];
                if (final_bit) begin
                    state_d = ST_PARITY;
                end
`else
                if (final_bit) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Left-align the word so the MSB of the used field leaves first.
        if (accept) begin
            state_d = ST_SHIFT;
            cnt_d   = eff_len;
            shreg_d = load_data << (LEN_W'(WIDTH) - eff_len);
`ifdef SERIALIZER_PARITY_EN
            par_d   = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer; honours SERIALIZER_PARITY_EN if defined.
module tb_bit_serializer;

    localparam int WIDTH = 16;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             load_valid;
    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .last       (last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
        logic [WIDTH-1:0] exp_bits;
        int               n;
        logic             par;
    } vec_t;

    vec_t vecs[8];

`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {out,valid,last,busy} got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_word(input int idx);
        load_data  = vecs[idx].data;
        load_len   = vecs[idx].len;
        load_valid = 1'b1;
    endtask

    // Offers nw words (i0, then i1) with load_valid held, checks every output cycle
    // plus one idle cycle; pulse_k >= 0 injects a spurious offer in that cycle.
    task automatic run_stream(input string name, input int i0, input int i1, input int nw, input int pulse_k);
        logic [3:0] exp_q[$];
        int         ids[2];
        int         w;
        logic       hs;
        logic       pulsed;
        ids[0] = i0;
        ids[1] = i1;
        for (int j = 0; j < nw; j++) begin
            for (int b = 0; b < vecs[ids[j]].n; b++)
                exp_q.push_back({vecs[ids[j]].exp_bits[WIDTH-1-b], 1'b1,
                                 (b == vecs[ids[j]].n - 1) && !PAR_EN, 1'b1});
            if (PAR_EN) exp_q.push_back({vecs[ids[j]].par, 3'b111});
        end
        exp_q.push_back(4'b0000);

        @(negedge clk);
        drive_word(ids[0]);
        check1({name, " ready_idle"}, load_ready, 1'b1);
        @(posedge clk);
        #1;
        w = 1;
        if (nw > 1) drive_word(ids[1]);
        else load_valid = 1'b0;

        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            pulsed = 1'b0;
            if (k == pulse_k) begin
                load_data  = 16'hFFFF;
                load_len   = LEN_W'(16);
                load_valid = 1'b1;
                pulsed     = 1'b1;
                check1({name, " ready_busy"}, load_ready, 1'b0);
            end
            hs = load_valid && load_ready;
            check4(name, {out, out_valid, last, busy}, exp_q[k]);
            @(posedge clk);
            #1;
            if (pulsed && !hs) load_valid = 1'b0;
            if (hs) begin
                w++;
                if (w < nw) drive_word(ids[w]);
                else load_valid = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'h01DB, 5'd9,  16'hED80, 9,  1'b1};
        vecs[1] = '{16'h02DB, 5'd10, 16'hB6C0, 10, 1'b1};
        vecs[2] = '{16'hA5C3, 5'd0,  16'hA5C3, 16, 1'b0};
        vecs[3] = '{16'h0006, 5'd4,  16'h6000, 4,  1'b0};
        vecs[4] = '{16'hFFFE, 5'd1,  16'h0000, 1,  1'b0};
        vecs[5] = '{16'h8001, 5'd20, 16'h8001, 16, 1'b0};
        vecs[6] = '{16'hFF05, 5'd4,  16'h5000, 4,  1'b0};
        vecs[7] = '{16'h0007, 5'd3,  16'hE000, 3,  1'b1};

        rst        = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_valid = 1'b0;
        #12;
        check4("reset_outputs", {out, out_valid, last, busy}, 4'b0000);
        check1("reset_ready", load_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_stream($sformatf("vec%0d", i), i, i, 1, -1);

        run_stream("b2b_9_10", 0, 1, 2, -1);
        run_stream("b2b_1_3", 4, 7, 2, -1);
        run_stream("ignored_pulse", 0, 0, 1, 3);

        // Reset during bit 4 of a 9-bit word.
        @(negedge clk);
        drive_word(0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check4("mid_bit4", {out, out_valid, last, busy}, 4'b0101);
        #2;
        rst = 1'b0;
        #1;
        check4("mid_reset_drop", {out, out_valid, last, busy}, 4'b0000);
        check1("mid_reset_ready", load_ready, 1'b1);
        drive_word(2);
        @(posedge clk);
        @(negedge clk);
        check4("reset_no_accept", {out, out_valid, last, busy}, 4'b0000);
        rst        = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        check4("post_reset_idle", {out, out_valid, last, busy}, 4'b0000);
        run_stream("after_reset", 3, 3, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
